mem_responder: RTL and testbench

- Byte-wide memory slave that answers the multicycle processor's memory port: adr, writedata, memread and memwrite in; memdata out.
- Adds a memready handshake with a programmable number of wait states.
- Has a host load port for preloading programs before or between processor runs.
- Sits outside the processor core as the far end of its memory interface; the 32-bit instruction is still fetched one byte per access.

---
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Byte-wide memory slave for the multicycle CPU memory port: memready handshake after
// WAIT_CYCLES wait states, plus a host preload port. Optional write protection: MEM_WPROT_EN.
module mem_responder #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int PROT_LIMIT  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] writedata,
  input  logic          memread,
  input  logic          memwrite,
  output logic [DW-1:0] memdata,
  output logic          memready,
  output logic          err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_adr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WC = WAIT_CYCLES[3:0];

  logic [DW-1:0] mem [2**AW];

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wd_q;
  logic          wr_q, both_q, err_q;

  logic          take, commit, c_wr, c_both, c_prot;
  logic [AW-1:0] c_adr;
  logic [DW-1:0] c_wd;

  // With zero wait states the commit happens on the sampling edge, so the
  // commit operands come straight from the port instead of the latched copy.
  always_comb begin
    take   = (state == S_IDLE) && !ld_en && (memread || memwrite);
    commit = (take && (WC == 4'd0)) || ((state == S_WAIT) && (cnt == 4'd1));
    if (state == S_IDLE) begin
      c_adr  = adr;
      c_wd   = writedata;
      c_wr   = memwrite;
      c_both = memread && memwrite;
    end else begin
      c_adr  = adr_q;
      c_wd   = wd_q;
      c_wr   = wr_q;
      c_both = both_q;
    end
  end

`ifdef MEM_WPROT_EN
  localparam logic [AW:0] PLIM = PROT_LIMIT[AW:0];
  assign c_prot = c_wr && ({1'b0, c_adr} < PLIM);
`else
  assign c_prot = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (take) begin
        cnt_nxt   = WC;
        state_nxt = (WC == 4'd0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      memdata <= '0;
      adr_q   <= '0;
      wd_q    <= '0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        adr_q  <= adr;
        wd_q   <= writedata;
        wr_q   <= memwrite;
        both_q <= memread && memwrite;
      end
      if (commit) begin
        err_q <= c_both || c_prot;
        if (!c_wr) memdata <= mem[c_adr];
      end
    end
  end

  // Array is deliberately not reset so a preloaded program survives a CPU reset;
  // writes are gated by reset so a host write on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      if ((state == S_IDLE) && ld_en)
        mem[ld_adr] <= ld_data;
      else if (commit && c_wr && !c_prot)
        mem[c_adr] <= c_wd;
    end
  end

  assign memready = (state == S_RESP);
  assign err      = memready && err_q;
  assign ld_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized accesses
// against a byte-array reference model.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] adr = '0, writedata = '0, ld_adr = '0, ld_data = '0;
  logic       memread = 1'b0, memwrite = 1'b0, ld_en = 1'b0;
  logic [7:0] memdata;
  logic       memready, err, ld_busy;

  logic [7:0] z_adr = '0, z_writedata = '0, z_ld_adr = '0, z_ld_data = '0;
  logic       z_memread = 1'b0, z_memwrite = 1'b0, z_ld_en = 1'b0;
  logic [7:0] z_memdata;
  logic       z_memready, z_err, z_ld_busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [256];
  logic [7:0] ref_md = 8'h00;

  always #5 clk = ~clk;

  mem_responder #(.AW(8), .DW(8), .WAIT_CYCLES(2), .PROT_LIMIT(64)) u_dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
    .memread(memread), .memwrite(memwrite), .memdata(memdata),
    .memready(memready), .err(err), .ld_en(ld_en), .ld_adr(ld_adr),
    .ld_data(ld_data), .ld_busy(ld_busy)
  );

  mem_responder #(.AW(8), .DW(8), .WAIT_CYCLES(0), .PROT_LIMIT(64)) u_dut0 (
    .clk(clk), .reset(reset), .adr(z_adr), .writedata(z_writedata),
    .memread(z_memread), .memwrite(z_memwrite), .memdata(z_memdata),
    .memready(z_memready), .err(z_err), .ld_en(z_ld_en), .ld_adr(z_ld_adr),
    .ld_data(z_ld_data), .ld_busy(z_ld_busy)
  );

  function automatic logic is_prot(input logic wr, input logic [7:0] a);
`ifdef MEM_WPROT_EN
    return wr && (a < 8'd64);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: a write is any access with memwrite; err on both-high or protected write.
  task automatic model_access(input logic rd, input logic wr, input logic [7:0] a,
                              input logic [7:0] d, output logic [7:0] exp_md,
                              output logic exp_err);
    exp_err = (rd && wr) || is_prot(wr, a);
    if (wr) begin
      if (!is_prot(wr, a)) ref_mem[a] = d;
    end else begin
      ref_md = ref_mem[a];
    end
    exp_md = ref_md;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_adr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issues one request from IDLE; lat counts edges from the sampling edge to memready.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, output int lat, output logic [7:0] md,
                        output logic e);
    memread = rd; memwrite = wr; adr = a; writedata = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!memready && lat < 20);
    md = memdata; e = err;
    memread = 1'b0; memwrite = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({memdata, memready, err, ld_busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got md=%h rdy=%b err=%b busy=%b want all 0",
               memdata, memready, err, ld_busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) host_write(i[7:0], 8'($urandom));
    host_write(8'h00, 8'h20);
    host_write(8'h01, 8'h03);
    host_write(8'h02, 8'h00);
    host_write(8'h03, 8'h05);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ref_md = 8'h00;
    checks++;
    if (memdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_memdata got %h want 00", memdata);
    end
  endtask

  task automatic test_preload_read();
    int lat; logic [7:0] md, emd; logic e, ee;
    access(1'b1, 1'b0, 8'h02, 8'h00, lat, md, e);
    model_access(1'b1, 1'b0, 8'h02, 8'h00, emd, ee);
    checks++;
    if (lat !== 3 || md !== 8'h00 || e !== 1'b0) begin
      errors++;
      $display("FAIL preload_read2 got lat=%0d md=%h err=%b want lat=3 md=00 err=0", lat, md, e);
    end
    access(1'b1, 1'b0, 8'h03, 8'h00, lat, md, e);
    model_access(1'b1, 1'b0, 8'h03, 8'h00, emd, ee);
    checks++;
    if (lat !== 3 || md !== 8'h05 || e !== 1'b0) begin
      errors++;
      $display("FAIL preload_read3 got lat=%0d md=%h err=%b want lat=3 md=05 err=0", lat, md, e);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] md, emd; logic e, ee;
    access(1'b0, 1'b1, 8'h80, 8'h0C, lat, md, e);
    model_access(1'b0, 1'b1, 8'h80, 8'h0C, emd, ee);
    checks++;
    if (lat !== 3 || md !== emd || e !== ee) begin
      errors++;
      $display("FAIL write_80 got lat=%0d md=%h err=%b want lat=3 md=%h err=%b", lat, md, e, emd, ee);
    end
    access(1'b1, 1'b0, 8'h80, 8'h00, lat, md, e);
    model_access(1'b1, 1'b0, 8'h80, 8'h00, emd, ee);
    checks++;
    if (md !== 8'h0C || e !== 1'b0) begin
      errors++;
      $display("FAIL readback_80 got md=%h err=%b want md=0C err=0", md, e);
    end
  endtask

  task automatic test_zero_wait();
    z_ld_en = 1'b1; z_ld_adr = 8'h01; z_ld_data = 8'h3C;
    @(posedge clk); #1;
    z_ld_en = 1'b0;
    z_memread = 1'b1; z_adr = 8'h01;
    @(posedge clk); #1;
    checks++;
    if (z_memready !== 1'b1 || z_memdata !== 8'h3C) begin
      errors++;
      $display("FAIL zero_wait_first got rdy=%b md=%h want rdy=1 md=3c", z_memready, z_memdata);
    end
    @(posedge clk); #1;
    checks++;
    if (z_memready !== 1'b0) begin
      errors++;
      $display("FAIL zero_wait_gap got rdy=%b want 0", z_memready);
    end
    @(posedge clk); #1;
    checks++;
    if (z_memready !== 1'b1 || z_memdata !== 8'h3C) begin
      errors++;
      $display("FAIL zero_wait_second got rdy=%b md=%h want rdy=1 md=3c", z_memready, z_memdata);
    end
    z_memread = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    int lat; logic [7:0] md, emd, old; logic e, ee;
    ld_en = 1'b1; ld_adr = 8'h05; ld_data = 8'h07;
    memread = 1'b1; adr = 8'h05;
    @(posedge clk); #1;
    ld_en = 1'b0;
    ref_mem[5] = 8'h07;
    checks++;
    if (ld_busy !== 1'b0) begin
      errors++;
      $display("FAIL collision_defer got busy=%b want 0", ld_busy);
    end
    lat = 1;
    while (!memready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    md = memdata;
    memread = 1'b0;
    @(posedge clk); #1;
    model_access(1'b1, 1'b0, 8'h05, 8'h00, emd, ee);
    checks++;
    if (lat !== 4 || md !== 8'h07) begin
      errors++;
      $display("FAIL collision_read got lat=%0d md=%h want lat=4 md=07", lat, md);
    end
    old = ref_mem[20];
    memread = 1'b1; adr = 8'd20;
    @(posedge clk); #1;
    ld_en = 1'b1; ld_adr = 8'd20; ld_data = ~old;
    checks++;
    if (ld_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_wait got busy=%b want 1", ld_busy);
    end
    lat = 1;
    while (!memready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    md = memdata;
    ld_en = 1'b0; memread = 1'b0;
    @(posedge clk); #1;
    model_access(1'b1, 1'b0, 8'd20, 8'h00, emd, ee);
    checks++;
    if (md !== old) begin
      errors++;
      $display("FAIL busy_inflight_read got md=%h want %h", md, old);
    end
    access(1'b1, 1'b0, 8'd20, 8'h00, lat, md, e);
    model_access(1'b1, 1'b0, 8'd20, 8'h00, emd, ee);
    checks++;
    if (md !== old) begin
      errors++;
      $display("FAIL busy_ignored got md=%h want %h", md, old);
    end
  endtask

  task automatic test_error_reset();
    int lat; logic [7:0] md, emd, old10, old11; logic e, ee;
    access(1'b1, 1'b1, 8'd9, 8'h0B, lat, md, e);
    model_access(1'b1, 1'b1, 8'd9, 8'h0B, emd, ee);
    checks++;
    if (lat !== 3 || e !== 1'b1 || md !== emd) begin
      errors++;
      $display("FAIL both_high got lat=%0d err=%b md=%h want lat=3 err=1 md=%h", lat, e, md, emd);
    end
    access(1'b1, 1'b0, 8'd9, 8'h00, lat, md, e);
    model_access(1'b1, 1'b0, 8'd9, 8'h00, emd, ee);
    checks++;
    if (md !== emd || e !== 1'b0) begin
      errors++;
      $display("FAIL both_high_readback got md=%h err=%b want md=%h err=0", md, e, emd);
    end
    old10 = ref_mem[10]; old11 = ref_mem[11];
    memwrite = 1'b1; adr = 8'd10; writedata = ~old10;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({memdata, memready, err, ld_busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_in_wait got md=%h rdy=%b err=%b busy=%b want all 0",
               memdata, memready, err, ld_busy);
    end
    memwrite = 1'b0;
    ld_en = 1'b1; ld_adr = 8'd11; ld_data = ~old11;
    @(posedge clk); #1;
    ld_en = 1'b0;
    reset = 1'b1;
    ref_md = 8'h00;
    access(1'b1, 1'b0, 8'd10, 8'h00, lat, md, e);
    model_access(1'b1, 1'b0, 8'd10, 8'h00, emd, ee);
    checks++;
    if (md !== old10) begin
      errors++;
      $display("FAIL dropped_write got md=%h want %h", md, old10);
    end
    access(1'b1, 1'b0, 8'd11, 8'h00, lat, md, e);
    model_access(1'b1, 1'b0, 8'd11, 8'h00, emd, ee);
    checks++;
    if (md !== old11) begin
      errors++;
      $display("FAIL dropped_host_write got md=%h want %h", md, old11);
    end
  endtask

  task automatic test_protect();
    int lat; logic [7:0] md, emd; logic e, ee;
    access(1'b0, 1'b1, 8'h10, 8'hFF, lat, md, e);
    model_access(1'b0, 1'b1, 8'h10, 8'hFF, emd, ee);
    checks++;
    if (lat !== 3 || e !== ee || md !== emd) begin
      errors++;
      $display("FAIL prot_write_10 got lat=%0d err=%b md=%h want lat=3 err=%b md=%h", lat, e, md, ee, emd);
    end
    access(1'b1, 1'b0, 8'h10, 8'h00, lat, md, e);
    model_access(1'b1, 1'b0, 8'h10, 8'h00, emd, ee);
    checks++;
    if (md !== emd) begin
      errors++;
      $display("FAIL prot_readback_10 got md=%h want %h", md, emd);
    end
    access(1'b0, 1'b1, 8'h40, 8'h5A, lat, md, e);
    model_access(1'b0, 1'b1, 8'h40, 8'h5A, emd, ee);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL prot_write_40 got err=%b want 0", e);
    end
    access(1'b1, 1'b0, 8'h40, 8'h00, lat, md, e);
    model_access(1'b1, 1'b0, 8'h40, 8'h00, emd, ee);
    checks++;
    if (md !== 8'h5A) begin
      errors++;
      $display("FAIL prot_readback_40 got md=%h want 5a", md);
    end
  endtask

  task automatic test_random();
    int lat; logic [7:0] md, emd, a, d; logic e, ee, rd, wr;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) host_write(8'($urandom), 8'($urandom));
      case ($urandom_range(0, 4))
        0, 1:    begin rd = 1'b1; wr = 1'b0; end
        2, 3:    begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      a = 8'($urandom); d = 8'($urandom);
      access(rd, wr, a, d, lat, md, e);
      model_access(rd, wr, a, d, emd, ee);
      checks++;
      if (lat !== 3 || md !== emd || e !== ee) begin
        errors++;
        $display("FAIL random_%0d rd=%b wr=%b a=%h got lat=%0d md=%h err=%b want lat=3 md=%h err=%b",
                 i, rd, wr, a, lat, md, e, emd, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_write_read();
    test_zero_wait();
    test_collision();
    test_error_reset();
    test_protect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
